// File: rtl/sspim_pkg.sv
// sspim_pkg: shared arbiter FSM states and SPI op-type codes
package sspim_pkg;
   typedef enum logic [1:0] {ARB_IDLE, ARB_RUN, ARB_DONE, ARB_GAP} arb_state_e;
   localparam logic [1:0] SPI_OP_WR = 2'd0;
   localparam logic [1:0] SPI_OP_RD = 2'd1;
endpackage

// File: rtl/sspim_rr_pick.sv
// sspim_rr_pick: combinational pick of the first valid requester at or after ptr, wrapping
module sspim_rr_pick #(
   parameter int NREQ = 2,
   parameter int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] valid,
   input  logic [GW-1:0]   ptr,
   output logic [GW-1:0]   idx,
   output logic            any
);
   int best;
   int off;
   // smallest rotated distance from ptr among valid requesters wins
   always_comb begin
      idx  = '0;
      any  = |valid;
      best = NREQ;
      off  = 0;
      for (int i = 0; i < NREQ; i++) begin
         off = (i >= int'(ptr)) ? i - int'(ptr) : i + NREQ - int'(ptr);
         if (valid[i] && off < best) begin
            best = off;
            idx  = GW'(i);
         end
      end
   end
endmodule

// File: rtl/sspim_arb.sv
// sspim_arb: round-robin sequencer sharing one sspim_ctl; SSPIM_ARB_FIXPRI_EN selects fixed priority
module sspim_arb
   import sspim_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [2*NREQ-1:0] req_op_type,
   input  logic [2*NREQ-1:0] req_xfer_size,
   input  logic [8*NREQ-1:0] req_cs_byte,
   input  logic [32*NREQ-1:0] req_datain,
   output logic [NREQ-1:0]   resp_ack,
   output logic [31:0]       resp_data,
   output logic [GW-1:0]     grant_id,
   output logic              busy,
   output logic              cfg_op_req,
   output logic [1:0]        cfg_op_type,
   output logic [1:0]        cfg_transfer_size,
   output logic [7:0]        cfg_cs_byte,
   output logic [31:0]       cfg_datain,
   input  logic [31:0]       cfg_dataout,
   input  logic              op_done
);
   arb_state_e state_q, state_d;
   logic [GW-1:0] ptr_q, ptr_d, grant_q, grant_d, win;
   logic busy_q, busy_d, op_req_q, op_req_d, any;
   logic [1:0] type_q, type_d, size_q, size_d;
   logic [7:0] cs_q, cs_d;
   logic [31:0] din_q, din_d, rdata_q, rdata_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic [1:0] type_a [NREQ];
   logic [1:0] size_a [NREQ];
   logic [7:0] cs_a [NREQ];
   logic [31:0] din_a [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign type_a[g] = req_op_type[2*g +: 2];
      assign size_a[g] = req_xfer_size[2*g +: 2];
      assign cs_a[g]   = req_cs_byte[8*g +: 8];
      assign din_a[g]  = req_datain[32*g +: 32];
   end

   sspim_rr_pick #(.NREQ(NREQ), .GW(GW)) u_pick (
      .valid (req_valid),
      .ptr   (ptr_q),
      .idx   (win),
      .any   (any)
   );

   // arbiter FSM: grant, wait for ctl completion, ack, then wait for ctl idle before next grant
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      busy_d   = busy_q;
      op_req_d = op_req_q;
      type_d   = type_q;
      size_d   = size_q;
      cs_d     = cs_q;
      din_d    = din_q;
      rdata_d  = rdata_q;
      ack_d    = '0;
      case (state_q)
         ARB_IDLE: if (!op_done && any) begin
            state_d  = ARB_RUN;
            grant_d  = win;
            busy_d   = 1'b1;
            op_req_d = 1'b1;
            type_d   = type_a[win];
            size_d   = size_a[win];
            cs_d     = cs_a[win];
            din_d    = din_a[win];
         end
         ARB_RUN: if (op_done) begin
            state_d  = ARB_DONE;
            rdata_d  = cfg_dataout;
            ack_d    = NREQ'(1) << grant_q;
            op_req_d = 1'b0;
         end
         ARB_DONE: begin
            state_d = ARB_GAP;
`ifdef SSPIM_ARB_FIXPRI_EN
            ptr_d   = '0;
`else
            ptr_d   = (grant_q == GW'(NREQ-1)) ? '0 : grant_q + 1'b1;
`endif
         end
         ARB_GAP: if (!op_done) begin
            state_d = ARB_IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // state registers, cleared by the reset shared with sspim_ctl
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ARB_IDLE;
         ptr_q    <= '0;
         grant_q  <= '0;
         busy_q   <= 1'b0;
         op_req_q <= 1'b0;
         type_q   <= '0;
         size_q   <= '0;
         cs_q     <= '0;
         din_q    <= '0;
         rdata_q  <= '0;
         ack_q    <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         busy_q   <= busy_d;
         op_req_q <= op_req_d;
         type_q   <= type_d;
         size_q   <= size_d;
         cs_q     <= cs_d;
         din_q    <= din_d;
         rdata_q  <= rdata_d;
         ack_q    <= ack_d;
      end
   end

   assign resp_ack          = ack_q;
   assign resp_data         = rdata_q;
   assign grant_id          = grant_q;
   assign busy              = busy_q;
   assign cfg_op_req        = op_req_q;
   assign cfg_op_type       = type_q;
   assign cfg_transfer_size = size_q;
   assign cfg_cs_byte       = cs_q;
   assign cfg_datain        = din_q;
endmodule
